// File: rtl/watch_core_param.sv
// Cascaded time-of-day counter with run/pause, 12/24h display, field adjust and validated load.
// Optional alarm output enabled by defining WATCH_ALARM_EN.
module watch_core_param #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SUB_HZ   = 100,
    parameter int RST_HOUR = 12,
    localparam int SUB_W   = $clog2(SUB_HZ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             mode_12h,
    input  logic [1:0]       sel,
    input  logic             adj_up,
    input  logic             adj_down,
    input  logic             load,
    input  logic [4:0]       ld_hour,
    input  logic [5:0]       ld_min,
    input  logic [5:0]       ld_sec,
    input  logic             alarm_arm,
    input  logic [4:0]       alarm_hour,
    input  logic [5:0]       alarm_min,
    output logic [SUB_W-1:0] subsec,
    output logic [5:0]       sec,
    output logic [5:0]       min,
    output logic [4:0]       hour,
    output logic [4:0]       hour_disp,
    output logic             pm,
    output logic             sec_tick,
    output logic             load_err,
    output logic             alarm_hit
);

    localparam int DIV  = CLK_HZ / SUB_HZ;
    localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(DIV - 1);
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(SUB_HZ - 1);
    localparam logic [4:0]       RST_H   = 5'(RST_HOUR);

    logic [PS_W-1:0]  r_ps,   w_ps_n;
    logic [SUB_W-1:0] r_sub,  w_sub_n;
    logic [5:0]       r_sec,  w_sec_n;
    logic [5:0]       r_min,  w_min_n;
    logic [4:0]       r_hour, w_hour_n;
    logic             r_sec_tick, r_load_err, r_alarm_hit;
    logic             w_tick, w_ld_ok, w_adj_ok, w_sec_carry, w_alarm;

    assign w_tick   = run && (r_ps == PS_MAX);
    assign w_ld_ok  = (ld_hour < 5'd24) && (ld_min < 6'd60) && (ld_sec < 6'd60);
    assign w_adj_ok = (sel != 2'd3) && (adj_up ^ adj_down);

    // Next-state: load beats adjust beats sub tick; a consumed cycle drops the tick
    always_comb begin
        w_sub_n     = r_sub;
        w_sec_n     = r_sec;
        w_min_n     = r_min;
        w_hour_n    = r_hour;
        w_sec_carry = 1'b0;
        if (run) begin
            w_ps_n = (r_ps == PS_MAX) ? {PS_W{1'b0}} : r_ps + PS_W'(1);
        end else begin
            w_ps_n = r_ps;
        end

        if (load) begin
            if (w_ld_ok) begin
                w_hour_n = ld_hour;
                w_min_n  = ld_min;
                w_sec_n  = ld_sec;
                w_sub_n  = {SUB_W{1'b0}};
                w_ps_n   = {PS_W{1'b0}};
            end else begin
                w_sub_n = r_sub;
            end
        end else if (w_adj_ok) begin
            case (sel)
                2'd0: begin
                    if (adj_up) begin
                        w_sec_n = (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
                    end else begin
                        w_sec_n = (r_sec == 6'd0) ? 6'd59 : r_sec - 6'd1;
                    end
                    w_sub_n = {SUB_W{1'b0}};
                end
                2'd1: begin
                    if (adj_up) begin
                        w_min_n = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
                    end else begin
                        w_min_n = (r_min == 6'd0) ? 6'd59 : r_min - 6'd1;
                    end
                end
                2'd2: begin
                    if (adj_up) begin
                        w_hour_n = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
                    end else begin
                        w_hour_n = (r_hour == 5'd0) ? 5'd23 : r_hour - 5'd1;
                    end
                end
                default: begin
                    w_sub_n = r_sub;
                end
            endcase
        end else if (w_tick) begin
            if (r_sub == SUB_MAX) begin
                w_sub_n     = {SUB_W{1'b0}};
                w_sec_carry = 1'b1;
                if (r_sec == 6'd59) begin
                    w_sec_n = 6'd0;
                    if (r_min == 6'd59) begin
                        w_min_n  = 6'd0;
                        w_hour_n = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
                    end else begin
                        w_min_n = r_min + 6'd1;
                    end
                end else begin
                    w_sec_n = r_sec + 6'd1;
                end
            end else begin
                w_sub_n = r_sub + SUB_W'(1);
            end
        end else begin
            w_sub_n = r_sub;
        end
    end

`ifdef WATCH_ALARM_EN
    // Only a tick carry that lands exactly on hh:mm:00.0 can fire
    assign w_alarm = alarm_arm && w_sec_carry && (r_sec == 6'd59) &&
                     (w_min_n == alarm_min) && (w_hour_n == alarm_hour);
`else
    logic w_alarm_unused;
    assign w_alarm_unused = ^{alarm_arm, alarm_hour, alarm_min};
    assign w_alarm        = 1'b0;
`endif

    // State and pulse registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ps        <= {PS_W{1'b0}};
            r_sub       <= {SUB_W{1'b0}};
            r_sec       <= 6'd0;
            r_min       <= 6'd0;
            r_hour      <= RST_H;
            r_sec_tick  <= 1'b0;
            r_load_err  <= 1'b0;
            r_alarm_hit <= 1'b0;
        end else begin
            r_ps        <= w_ps_n;
            r_sub       <= w_sub_n;
            r_sec       <= w_sec_n;
            r_min       <= w_min_n;
            r_hour      <= w_hour_n;
            r_sec_tick  <= w_sec_carry;
            r_load_err  <= load && !w_ld_ok;
            r_alarm_hit <= w_alarm;
        end
    end

    assign subsec    = r_sub;
    assign sec       = r_sec;
    assign min       = r_min;
    assign hour      = r_hour;
    assign pm        = (r_hour >= 5'd12);
    assign sec_tick  = r_sec_tick;
    assign load_err  = r_load_err;
    assign alarm_hit = r_alarm_hit;
    assign hour_disp = !mode_12h          ? r_hour :
                       (r_hour == 5'd0)   ? 5'd12 :
                       (r_hour > 5'd12)   ? r_hour - 5'd12 : r_hour;

endmodule

// File: tb/tb_watch_core_param.sv
// Randomized self-checking bench for watch_core_param; reference model keeps time as a
// single count of sub-ticks since midnight. Alarm scenario runs when WATCH_ALARM_EN is defined.
module tb_watch_core_param;

    localparam int CLK_HZ = 1000;
    localparam int SUB_HZ = 10;
    localparam int DIV    = CLK_HZ / SUB_HZ;
    localparam int DAY    = 86400 * SUB_HZ;
    localparam int RST_HR = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       mode_12h = 1'b0;
    logic [1:0] sel = 2'd3;
    logic       adj_up = 1'b0;
    logic       adj_down = 1'b0;
    logic       load = 1'b0;
    logic [4:0] ld_hour = 5'd0;
    logic [5:0] ld_min = 6'd0;
    logic [5:0] ld_sec = 6'd0;
    logic       alarm_arm = 1'b0;
    logic [4:0] alarm_hour = 5'd0;
    logic [5:0] alarm_min = 6'd0;
    logic [3:0] subsec;
    logic [5:0] sec, min;
    logic [4:0] hour, hour_disp;
    logic       pm, sec_tick, load_err, alarm_hit;
    logic [29:0] dut_vec;

    int checks = 0;
    int errors = 0;
    int m_t, m_ps;
    bit m_st, m_le, m_al;

    watch_core_param #(.CLK_HZ(CLK_HZ), .SUB_HZ(SUB_HZ), .RST_HOUR(RST_HR)) dut (
        .clk(clk), .rst(rst), .run(run), .mode_12h(mode_12h), .sel(sel),
        .adj_up(adj_up), .adj_down(adj_down), .load(load),
        .ld_hour(ld_hour), .ld_min(ld_min), .ld_sec(ld_sec),
        .alarm_arm(alarm_arm), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .subsec(subsec), .sec(sec), .min(min), .hour(hour), .hour_disp(hour_disp),
        .pm(pm), .sec_tick(sec_tick), .load_err(load_err), .alarm_hit(alarm_hit)
    );

    always #5 clk = ~clk;

    assign dut_vec = {subsec, sec, min, hour, hour_disp, pm, sec_tick, load_err, alarm_hit};

    // Reference model: advance one clock using the inputs currently applied
    task automatic model_step();
        int h, m, s, u, d, ps_n;
        bit tick;
        if (rst) begin
            m_t = RST_HR * 3600 * SUB_HZ; m_ps = 0; m_st = 0; m_le = 0; m_al = 0;
            return;
        end
        tick = run && (m_ps == DIV - 1);
        ps_n = run ? (m_ps + 1) % DIV : m_ps;
        m_st = 0; m_le = 0; m_al = 0;
        if (load) begin
            if (int'(ld_hour) < 24 && int'(ld_min) < 60 && int'(ld_sec) < 60) begin
                m_t  = ((int'(ld_hour) * 60 + int'(ld_min)) * 60 + int'(ld_sec)) * SUB_HZ;
                ps_n = 0;
            end else begin
                m_le = 1;
            end
        end else if (sel != 2'd3 && adj_up != adj_down) begin
            u = m_t % SUB_HZ;
            s = (m_t / SUB_HZ) % 60;
            m = (m_t / (SUB_HZ * 60)) % 60;
            h = m_t / (SUB_HZ * 3600);
            d = adj_up ? 1 : -1;
            if (sel == 2'd0) begin s = (s + d + 60) % 60; u = 0; end
            else if (sel == 2'd1) m = (m + d + 60) % 60;
            else h = (h + d + 24) % 24;
            m_t = ((h * 60 + m) * 60 + s) * SUB_HZ + u;
        end else if (tick) begin
            m_st = (m_t % SUB_HZ == SUB_HZ - 1);
            m_t  = (m_t + 1) % DAY;
`ifdef WATCH_ALARM_EN
            m_al = alarm_arm && (m_t == (int'(alarm_hour) * 60 + int'(alarm_min)) * 60 * SUB_HZ);
`endif
        end
        m_ps = ps_n;
    endtask

    function automatic logic [29:0] exp_vec();
        int h, hd;
        h  = m_t / (SUB_HZ * 3600);
        hd = !mode_12h ? h : (h == 0) ? 12 : (h > 12) ? h - 12 : h;
        return {4'(m_t % SUB_HZ), 6'((m_t / SUB_HZ) % 60), 6'((m_t / (SUB_HZ * 60)) % 60),
                5'(h), 5'(hd), (h >= 12), m_st, m_le, m_al};
    endfunction

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int h, input int m, input int s);
        ld_hour = 5'(h); ld_min = 6'(m); ld_sec = 6'(s); load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode_12h = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if ({hour, min, sec, subsec} !== {5'd12, 6'd0, 6'd0, 4'd0}) begin
            errors++; $display("FAIL reset_time: got %0d:%0d:%0d.%0d expected 12:0:0.0", hour, min, sec, subsec);
        end
        checks++;
        if ({hour_disp, pm} !== {5'd12, 1'b1}) begin
            errors++; $display("FAIL reset_disp: got disp=%0d pm=%0b expected 12/1", hour_disp, pm);
        end
        checks++;
        if ({sec_tick, load_err, alarm_hit} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b expected 000", {sec_tick, load_err, alarm_hit});
        end
    endtask

    task automatic test_rollover();
        mode_12h = 1'b1;
        do_load(23, 59, 59);
        run = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL rollover_cyc%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if ({hour, min, sec, subsec, pm, hour_disp} !== {5'd0, 6'd0, 6'd0, 4'd0, 1'b0, 5'd12}) begin
            errors++; $display("FAIL rollover_midnight: got %0d:%0d:%0d.%0d pm=%0b disp=%0d", hour, min, sec, subsec, pm, hour_disp);
        end
        checks++;
        if (sec_tick !== 1'b1) begin
            errors++; $display("FAIL rollover_sec_tick: got %b expected 1", sec_tick);
        end
        run = 1'b0;
        cyc();
        checks++;
        if (sec_tick !== 1'b0) begin
            errors++; $display("FAIL sec_tick_width: got %b expected 0", sec_tick);
        end
    endtask

    task automatic test_adjust();
        run = 1'b0; mode_12h = 1'b0;
        do_load(10, 0, 30);
        sel = 2'd1; adj_down = 1'b1;
        cyc();
        adj_down = 1'b0;
        checks++;
        if ({hour, min} !== {5'd10, 6'd59}) begin
            errors++; $display("FAIL adj_min_wrap: got %0d:%0d expected 10:59", hour, min);
        end
        do_load(23, 5, 0);
        sel = 2'd2; adj_up = 1'b1;
        cyc();
        adj_up = 1'b0;
        checks++;
        if ({hour, min} !== {5'd0, 6'd5}) begin
            errors++; $display("FAIL adj_hour_wrap: got %0d:%0d expected 0:5", hour, min);
        end
        for (int i = 0; i < 80; i++) begin
            sel = 2'($urandom_range(0, 3));
            adj_up = 1'($urandom_range(0, 1));
            adj_down = 1'($urandom_range(0, 1));
            run = ($urandom_range(0, 3) != 0);
            mode_12h = 1'($urandom_range(0, 1));
            cyc();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL adj_rand%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        adj_up = 1'b0; adj_down = 1'b0; sel = 2'd3; run = 1'b0;
    endtask

    task automatic test_load_err();
        do_load(8, 15, 20);
        do_load(8, 15, 60);
        checks++;
        if ({load_err, hour, min, sec} !== {1'b1, 5'd8, 6'd15, 6'd20}) begin
            errors++; $display("FAIL load_err_set: got err=%b %0d:%0d:%0d expected 1 8:15:20", load_err, hour, min, sec);
        end
        cyc();
        checks++;
        if (load_err !== 1'b0) begin
            errors++; $display("FAIL load_err_width: got %b expected 0", load_err);
        end
        for (int i = 0; i < 40; i++) begin
            run = 1'b1;
            ld_hour = 5'($urandom_range(0, 31));
            ld_min = 6'($urandom_range(0, 63));
            ld_sec = 6'($urandom_range(0, 63));
            load = ($urandom_range(0, 1) == 1);
            cyc();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL load_rand%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        load = 1'b0; run = 1'b0;
    endtask

    task automatic test_adjust_on_tick();
        do_load(5, 10, 20);
        run = 1'b1;
        repeat (DIV - 1) cyc();
        sel = 2'd0; adj_up = 1'b1;
        cyc();
        adj_up = 1'b0; run = 1'b0;
        checks++;
        if ({hour, min, sec, subsec} !== {5'd5, 6'd10, 6'd21, 4'd0}) begin
            errors++; $display("FAIL adj_on_tick: got %0d:%0d:%0d.%0d expected 5:10:21.0", hour, min, sec, subsec);
        end
        repeat (500) cyc();
        checks++;
        if (dut_vec !== exp_vec() || sec !== 6'd21 || subsec !== 4'd0) begin
            errors++; $display("FAIL paused: got %h expected %h", dut_vec, exp_vec());
        end
        sel = 2'd3;
    endtask

    task automatic test_random();
        alarm_arm = 1'b1; alarm_hour = 5'd0; alarm_min = 6'd0;
        for (int i = 0; i < 4000; i++) begin
            run = ($urandom_range(0, 9) != 0);
            mode_12h = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 499) == 0);
            load = ($urandom_range(0, 99) == 0);
            ld_hour = ($urandom_range(0, 1) == 1) ? 5'd23 : 5'($urandom_range(0, 24));
            ld_min = 6'($urandom_range(58, 60));
            ld_sec = 6'($urandom_range(57, 60));
            sel = 2'($urandom_range(0, 3));
            adj_up = ($urandom_range(0, 29) == 0);
            adj_down = ($urandom_range(0, 29) == 0);
            cyc();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL random%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        rst = 1'b0; load = 1'b0; adj_up = 1'b0; adj_down = 1'b0; sel = 2'd3; run = 1'b0;
    endtask

    task automatic test_alarm();
        int hits;
        alarm_arm = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30;
        do_load(7, 29, 59);
        run = 1'b1; hits = 0;
        for (int i = 0; i < 1100; i++) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL alarm_cyc%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
            if (alarm_hit === 1'b1) begin
                hits++;
                checks++;
                if ({hour, min, sec, subsec} !== {5'd7, 6'd30, 6'd0, 4'd0}) begin
                    errors++; $display("FAIL alarm_time: got %0d:%0d:%0d.%0d expected 7:30:0.0", hour, min, sec, subsec);
                end
            end
        end
`ifdef WATCH_ALARM_EN
        checks++;
        if (hits != 1) begin
            errors++; $display("FAIL alarm_count: got %0d expected 1", hits);
        end
`else
        checks++;
        if (hits != 0) begin
            errors++; $display("FAIL alarm_disabled: got %0d pulses expected 0", hits);
        end
`endif
        hits = 0;
        do_load(7, 30, 0);
        if (alarm_hit === 1'b1) hits++;
        run = 1'b0;
        do_load(7, 29, 0);
        sel = 2'd1; adj_up = 1'b1;
        cyc();
        adj_up = 1'b0; sel = 2'd3;
        if (alarm_hit === 1'b1) hits++;
        cyc();
        if (alarm_hit === 1'b1) hits++;
        checks++;
        if (hits != 0 || min !== 6'd30) begin
            errors++; $display("FAIL alarm_no_fire_on_set: got %0d pulses min=%0d expected 0 pulses min=30", hits, min);
        end
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_adjust();
        test_load_err();
        test_adjust_on_tick();
        test_alarm();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
